diff_m: RTL and testbench

Modulo-M first-difference unit: the inverse of the modulo-M accumulator. It takes the accumulator's running-sum stream `acc` and recovers each increment as `d = (acc - acc_prev) mod M`. Pipelined over two stages with valid/ready on both sides. Used to check or reconstruct increment streams downstream of an `AccuM` instance, and as its golden inverse in benches.

---
 rtl/diff_pkg.sv | 24 ++
 rtl/diff_m_pipe_reg.sv | 60 ++++++
 rtl/diff_m.sv | 98 +++++++++
 tb/tb_diff_m.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// Shared types and helpers for the modulo-M first-difference unit.
package diff_pkg;

  // Occupancy of one pipeline stage; the valid bit of a stage is its state.
  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stage_e;

  localparam int unsigned DEFAULT_M = 50;

  // Width needed to hold values 0..m-1.
  function automatic int unsigned width_of(input int unsigned m);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // (a - b) mod m for operands already in 0..m-1.
  function automatic int unsigned mod_sub(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned m);
    return (a >= b) ? (a - b) : (a + m - b);
  endfunction

endpackage

// File: rtl/diff_m_pipe_reg.sv
// One valid/ready register stage with synchronous flush.
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// never depends on ready, and ready depends only on the downstream ready and
// this stage's own occupancy.
module pipe_reg
  import diff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output stage_e           state_o
);

  stage_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;
  logic             drain;

  assign in_ready_o = (state_q == STG_EMPTY) || out_ready_i;
  assign load       = in_valid_i && in_ready_o;
  assign drain      = (state_q == STG_FULL) && out_ready_i;

  // Next state: flush wins, then load (possibly replacing a draining entry), then drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = STG_EMPTY;
    end else if (load) begin
      state_d = STG_FULL;
      data_d  = in_data_i;
    end else if (drain) begin
      state_d = STG_EMPTY;
    end
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STG_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = (state_q == STG_FULL);
  assign out_data_o  = data_q;
  assign state_o     = state_q;

endmodule

// File: rtl/diff_m.sv
// Modulo-M first difference: recovers increments from an accumulator stream.
// Handshake: input transfer on in_valid && in_ready, output transfer on
// out_valid && out_ready; in_ready is a function of out_ready and stage
// occupancy only, never of in_valid.
module diff_m
  import diff_pkg::*;
#(
  parameter  int M = DEFAULT_M,
  localparam int W = width_of(M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] acc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d_o,
  output logic         err,
  output logic [1:0]   dbg_state_o
);

  localparam logic [W:0] M_EXT = (W+1)'(M);

  logic [W-1:0] prev_q, prev_d;
  logic         err_q, err_d;
  logic         in_xfer;
  logic         illegal;
  logic [W:0]   s1_diff;
  logic [W:0]   s1_data;
  logic         s1_valid;
  logic         s2_ready;
  logic [W-1:0] s2_in;
  stage_e       s1_state;
  stage_e       s2_state;

  // clr drops any input offered in the same cycle.
  assign in_xfer = in_valid && in_ready && !clr;
  assign illegal = ({1'b0, acc_i} >= M_EXT);
  assign s1_diff = {1'b0, acc_i} - {1'b0, prev_q};

  // A negative raw difference wraps back into 0..M-1 by adding M.
  assign s2_in = s1_data[W] ? W'(s1_data + M_EXT) : s1_data[W-1:0];

  // Previous-sample and sticky error next state.
  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    if (clr) begin
      prev_d = '0;
    end else if (in_xfer) begin
      prev_d = acc_i;
      err_d  = err_q || illegal;
    end
  end

  // prev and err registers; err survives clr and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  pipe_reg #(.WIDTH(W+1)) u_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (s1_diff),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data),
    .state_o     (s1_state)
  );

  pipe_reg #(.WIDTH(W)) u_s2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (clr),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (d_o),
    .state_o     (s2_state)
  );

  assign err         = err_q;
  assign dbg_state_o = {s2_state, s1_state};

endmodule

// File: tb/tb_diff_m.sv
// Self-checking bench for diff_m (M=50) with a behavioural occupancy model.
module tb_diff_m;

  localparam int M = 50;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] acc_i = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] d_o;
  logic         err;
  logic [1:0]   dbg_state;

  diff_m #(.M(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .acc_i       (acc_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_o         (d_o),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];   // expected increments, oldest first
  bit           dc_q[$];    // entry is don't-care (illegal input involved)
  int           edge_q[$];  // edge index at which the sample was accepted
  logic [W-1:0] got_q[$];   // DUT outputs actually transferred
  int  prev_m;
  bit  err_m;
  bit  dc_next;
  int  cyc;
  int  acc_count;
  int  first_acc_cyc;
  int  first_ov_cyc;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    dc_q.delete();
    edge_q.delete();
    got_q.delete();
    prev_m        = 0;
    err_m         = 1'b0;
    dc_next       = 1'b0;
    cyc           = 0;
    acc_count     = 0;
    first_acc_cyc = -1;
    first_ov_cyc  = -1;
  endtask

  // ---------------- compare process ----------------
  // Checks on the falling edge, then advances the model by the coming rising edge.
  bit m_ov, m_s1, m_ir;
  int sz;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      sz   = exp_q.size();
      m_ov = (sz > 0) && (edge_q[0] < cyc);
      m_s1 = (sz == 2) || (sz == 1 && !m_ov);
      m_ir = (sz < 2) || out_ready;
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("in_ready", int'(in_ready), int'(m_ir));
      chk("err", int'(err), int'(err_m));
      chk("dbg_state", int'(dbg_state), int'({m_ov, m_s1}));
      if (m_ov && !dc_q[0]) chk("d_o", int'(d_o), int'(exp_q[0]));
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;

      cyc++;
      if (clr) begin
        exp_q.delete();
        dc_q.delete();
        edge_q.delete();
        prev_m  = 0;
        dc_next = 1'b0;
      end else begin
        if (m_ov && out_ready) begin
          got_q.push_back(d_o);
          void'(exp_q.pop_front());
          void'(dc_q.pop_front());
          void'(edge_q.pop_front());
        end
        if (in_valid && m_ir) begin
          acc_count++;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          edge_q.push_back(cyc);
          if (int'(acc_i) >= M) begin
            err_m = 1'b1;
            exp_q.push_back('0);
            dc_q.push_back(1'b1);
            dc_next = 1'b1;
          end else begin
            exp_q.push_back(W'((int'(acc_i) - prev_m + M) % M));
            dc_q.push_back(dc_next);
            dc_next = 1'b0;
          end
          prev_m = int'(acc_i);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input int a, input bit r, input bit c);
    in_valid  = v;
    acc_i     = W'(a);
    out_ready = r;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_d_o"}, int'(d_o), 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    reset_checks("reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    model_reset();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int e1[5]  = '{0, 1, 2, 3, 4};
  int v1[5]  = '{0, 1, 3, 6, 10};
  int e2[3]  = '{48, 1, 4};
  int v2[3]  = '{48, 49, 3};
  int v4[5]  = '{3, 10, 20, 30, 40};
  int e4[2]  = '{3, 7};
  int accum;

  initial begin
    #1;
    do_reset();

    // Running sums 0,1,3,6,10 give increments 0..4 with two-cycle latency.
    for (int i = 0; i < 5; i++) step(1'b1, v1[i], 1'b1, 1'b0);
    idle(4);
    chk("seq_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("seq_d", int'(got_q[i]), e1[i]);
    chk("latency_edges", first_ov_cyc - first_acc_cyc, 1);

    // Wrap-around: 3 after 49 is 3-49+50 = 4.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, v2[i], 1'b1, 1'b0);
    idle(4);
    chk("wrap_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("wrap_d", int'(got_q[i]), e2[i]);

    // Chained modulo-50 accumulator fed increments 0..63.
    do_reset();
    accum = 0;
    for (int d = 0; d < 64; d++) begin
      accum = (accum + d) % M;
      step(1'b1, accum, 1'b1, 1'b0);
    end
    idle(4);
    chk("chain_count", got_q.size(), 64);
    for (int i = 0; i < 64 && i < got_q.size(); i++) chk("chain_d", int'(got_q[i]), i % M);

    // Backpressure: two samples absorbed, then in_ready drops.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, v4[i], 1'b0, 1'b0);
    chk("bp_accepted", acc_count, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    idle(4);
    chk("bp_count", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++) chk("bp_d", int'(got_q[i]), e4[i]);

    // clr with both stages full discards both; the next input 7 yields 7.
    do_reset();
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    chk("clr_full_state", int'(dbg_state), 3);
    step(1'b1, 12, 1'b0, 1'b1);
    step(1'b1, 7, 1'b1, 1'b0);
    idle(4);
    chk("clr_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("clr_d", int'(got_q[0]), 7);
    chk("clr_err", int'(err), 0);

    // Illegal input sets err; it survives clr and is cleared only by reset.
    step(1'b1, 55, 1'b1, 1'b0);
    idle(2);
    chk("illegal_err", int'(err), 1);
    step(1'b0, 0, 1'b1, 1'b1);
    idle(1);
    chk("illegal_err_after_clr", int'(err), 1);
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 8, 1'b1, 1'b0);
    pulse_reset();
    idle(3);
    chk("post_pulse_out_valid", int'(out_valid), 0);

    // Randomised traffic with occasional clr, illegal values and reset pulses.
    for (int i = 0; i < 3000; i++) begin
      bit v, r, c;
      int a;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      a = ($urandom_range(0, 99) == 0) ? int'($urandom_range(50, 63))
                                       : int'($urandom_range(0, 49));
      if ($urandom_range(0, 999) == 0) pulse_reset();
      step(v, a, r, c);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
